// File: rtl/wave_seq_ctrl.sv
// Wave generator config controller: manual UART config or a programmable 8-entry sequence.
// Define WAVE_SEQ_LOOP_EN to make the sequence repeat instead of stopping after the last entry.
module wave_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_valid,
    input  logic [2:0] uart_wave,
    input  logic [5:0] uart_freq,
    input  logic       uart_noise,
    input  logic       prog_we,
    input  logic [2:0] prog_addr,
    input  logic [2:0] prog_wave,
    input  logic [5:0] prog_freq,
    input  logic       prog_noise,
    input  logic [7:0] prog_dwell,
    input  logic [2:0] seq_last,
    input  logic       seq_start,
    input  logic       seq_stop,
    input  logic       tick,
    output logic [2:0] wave_select,
    output logic [5:0] freq_select,
    output logic       white_noise_en,
    output logic       cfg_strobe,
    output logic       busy,
    output logic [2:0] seq_idx
);

    typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

    state_t     state, state_nx;
    logic [2:0] tbl_wave  [8];
    logic [5:0] tbl_freq  [8];
    logic       tbl_noise [8];
    logic [7:0] tbl_dwell [8];

    logic [7:0] dwell_cnt, cnt_nx;
    logic [2:0] idx_nx, wave_nx;
    logic [5:0] freq_nx;
    logic       noise_nx, strobe_nx;

    // Table writes are independent of the FSM; a LOAD in the same cycle sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                tbl_wave[i]  <= '0;
                tbl_freq[i]  <= '0;
                tbl_noise[i] <= 1'b0;
                tbl_dwell[i] <= '0;
            end
        end else if (prog_we) begin
            tbl_wave[prog_addr]  <= prog_wave;
            tbl_freq[prog_addr]  <= prog_freq;
            tbl_noise[prog_addr] <= prog_noise;
            tbl_dwell[prog_addr] <= prog_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            seq_idx        <= '0;
            dwell_cnt      <= '0;
            wave_select    <= '0;
            freq_select    <= '0;
            white_noise_en <= 1'b0;
            cfg_strobe     <= 1'b0;
        end else begin
            state          <= state_nx;
            seq_idx        <= idx_nx;
            dwell_cnt      <= cnt_nx;
            wave_select    <= wave_nx;
            freq_select    <= freq_nx;
            white_noise_en <= noise_nx;
            cfg_strobe     <= strobe_nx;
        end
    end

    // UART config always wins; otherwise stop beats normal sequencing.
    always_comb begin
        state_nx  = state;
        idx_nx    = seq_idx;
        cnt_nx    = dwell_cnt;
        wave_nx   = wave_select;
        freq_nx   = freq_select;
        noise_nx  = white_noise_en;
        strobe_nx = 1'b0;

        if (uart_valid) begin
            wave_nx   = uart_wave;
            freq_nx   = uart_freq;
            noise_nx  = uart_noise;
            strobe_nx = 1'b1;
            state_nx  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (seq_start) begin
                        idx_nx   = '0;
                        state_nx = LOAD;
                    end
                end
                LOAD: begin
                    if (seq_stop) begin
                        state_nx = IDLE;
                    end else begin
                        wave_nx   = tbl_wave[seq_idx];
                        freq_nx   = tbl_freq[seq_idx];
                        noise_nx  = tbl_noise[seq_idx];
                        strobe_nx = 1'b1;
                        cnt_nx    = (tbl_dwell[seq_idx] == 8'd0) ? 8'd1 : tbl_dwell[seq_idx];
                        state_nx  = DWELL;
                    end
                end
                DWELL: begin
                    if (seq_stop) begin
                        state_nx = IDLE;
                    end else if (tick) begin
                        if (dwell_cnt <= 8'd1) begin
                            cnt_nx = '0;
                            if (seq_idx < seq_last) begin
                                idx_nx   = seq_idx + 3'd1;
                                state_nx = LOAD;
                            end else begin
`ifdef WAVE_SEQ_LOOP_EN
                                idx_nx   = '0;
                                state_nx = LOAD;
`else
                                state_nx = IDLE;
`endif
                            end
                        end else begin
                            cnt_nx = dwell_cnt - 8'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model (honours WAVE_SEQ_LOOP_EN).
module tb_wave_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_valid = 1'b0;
    logic [2:0] uart_wave = '0;
    logic [5:0] uart_freq = '0;
    logic       uart_noise = 1'b0;
    logic       prog_we = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [2:0] prog_wave = '0;
    logic [5:0] prog_freq = '0;
    logic       prog_noise = 1'b0;
    logic [7:0] prog_dwell = '0;
    logic [2:0] seq_last = '0;
    logic       seq_start = 1'b0;
    logic       seq_stop = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] wave_select;
    logic [5:0] freq_select;
    logic       white_noise_en;
    logic       cfg_strobe;
    logic       busy;
    logic [2:0] seq_idx;

    wave_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .uart_valid(uart_valid), .uart_wave(uart_wave), .uart_freq(uart_freq), .uart_noise(uart_noise),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wave(prog_wave), .prog_freq(prog_freq),
        .prog_noise(prog_noise), .prog_dwell(prog_dwell),
        .seq_last(seq_last), .seq_start(seq_start), .seq_stop(seq_stop), .tick(tick),
        .wave_select(wave_select), .freq_select(freq_select), .white_noise_en(white_noise_en),
        .cfg_strobe(cfg_strobe), .busy(busy), .seq_idx(seq_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wave;
        int freq;
        int noise;
        int dwell;
    } entry_t;

    // Behavioural view: "playing" flag, "entry due to be applied" flag and ticks remaining.
    entry_t m_table [8];
    int m_wave = 0, m_freq = 0, m_noise = 0, m_strobe = 0;
    int m_playing = 0, m_due = 0, m_idx = 0, m_left = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int s_cyc [8];
    int s_wave [8];
    int s_idx [8];
    int ns;
    int start_cyc;
    bit found;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelEdge();
        if (rst) begin
            m_wave = 0; m_freq = 0; m_noise = 0; m_strobe = 0;
            m_playing = 0; m_due = 0; m_idx = 0; m_left = 0;
            for (int i = 0; i < 8; i++) m_table[i] = '{0, 0, 0, 0};
        end else begin
            m_strobe = 0;
            if (uart_valid) begin
                m_wave = int'(uart_wave); m_freq = int'(uart_freq); m_noise = int'(uart_noise);
                m_strobe = 1; m_playing = 0; m_due = 0;
            end else if (m_playing == 1 && seq_stop) begin
                m_playing = 0; m_due = 0;
            end else if (m_playing == 0) begin
                if (seq_start) begin
                    m_playing = 1; m_due = 1; m_idx = 0;
                end
            end else if (m_due == 1) begin
                m_wave  = m_table[m_idx].wave;
                m_freq  = m_table[m_idx].freq;
                m_noise = m_table[m_idx].noise;
                m_left  = (m_table[m_idx].dwell == 0) ? 1 : m_table[m_idx].dwell;
                m_strobe = 1; m_due = 0;
            end else if (tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_idx < int'(seq_last)) begin
                        m_idx = m_idx + 1; m_due = 1;
                    end else begin
`ifdef WAVE_SEQ_LOOP_EN
                        m_idx = 0; m_due = 1;
`else
                        m_playing = 0;
`endif
                    end
                end
            end
            if (prog_we)
                m_table[prog_addr] = '{int'(prog_wave), int'(prog_freq), int'(prog_noise), int'(prog_dwell)};
        end
    endtask

    // Advance one clock with the currently driven inputs and compare against the model.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        cyc++;
        checkOutput("wave", int'(wave_select), m_wave);
        checkOutput("freq", int'(freq_select), m_freq);
        checkOutput("noise", int'(white_noise_en), m_noise);
        checkOutput("strobe", int'(cfg_strobe), m_strobe);
        checkOutput("busy", int'(busy), m_playing);
        checkOutput("seq_idx", int'(seq_idx), m_idx);
    endtask

    task automatic clearInputs();
        rst = 0; uart_valid = 0; prog_we = 0; seq_start = 0; seq_stop = 0; tick = 0;
    endtask

    task automatic progEntry(input int addr, input int w, input int f, input int n, input int d);
        prog_we = 1; prog_addr = 3'(addr); prog_wave = 3'(w); prog_freq = 6'(f);
        prog_noise = 1'(n); prog_dwell = 8'(d);
        applyStimulus();
        prog_we = 0;
    endtask

    initial begin
        $display("[TB] start");
        rst = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_wave", int'(wave_select), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst = 0;

        // Manual UART config in IDLE
        uart_valid = 1; uart_wave = 3'd3; uart_freq = 6'd17; uart_noise = 1'b1;
        applyStimulus();
        uart_valid = 0;
        checkOutput("uart_wave", int'(wave_select), 3);
        checkOutput("uart_freq", int'(freq_select), 17);
        checkOutput("uart_noise", int'(white_noise_en), 1);
        checkOutput("uart_strobe", int'(cfg_strobe), 1);
        checkOutput("uart_busy", int'(busy), 0);
        applyStimulus();
        checkOutput("uart_strobe_off", int'(cfg_strobe), 0);

        // Three-entry program, tick every cycle
        progEntry(0, 1, 10, 0, 2);
        progEntry(1, 2, 20, 1, 0);
        progEntry(2, 4, 30, 0, 3);
        seq_last = 3'd2;
        seq_start = 1;
        applyStimulus();
        seq_start = 0;
        start_cyc = cyc;
        tick = 1;
        ns = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            if (cfg_strobe && ns < 8) begin
                s_cyc[ns] = cyc; s_wave[ns] = int'(wave_select); s_idx[ns] = int'(seq_idx);
                ns++;
            end
        end
        if (ns >= 3) begin
            checkOutput("e0_latency", s_cyc[0] - start_cyc, 1);
            checkOutput("e0_wave", s_wave[0], 1);
            checkOutput("e1_wave", s_wave[1], 2);
            checkOutput("e2_wave", s_wave[2], 4);
            checkOutput("e0_hold", s_cyc[1] - s_cyc[0], 3);
            checkOutput("e1_hold", s_cyc[2] - s_cyc[1], 2);
        end else begin
            checkOutput("seq_strobes", ns, 3);
        end
`ifdef WAVE_SEQ_LOOP_EN
        if (ns >= 4) begin
            checkOutput("wrap_wave", s_wave[3], 1);
            checkOutput("wrap_idx", s_idx[3], 0);
            checkOutput("e2_hold", s_cyc[3] - s_cyc[2], 4);
        end else begin
            checkOutput("wrap_strobes", ns, 4);
        end
        checkOutput("loop_busy", int'(busy), 1);
`else
        checkOutput("end_strobes", ns, 3);
        checkOutput("end_busy", int'(busy), 0);
        checkOutput("end_wave", int'(wave_select), 4);
`endif
        tick = 0;
        seq_stop = 1;
        applyStimulus();
        seq_stop = 0;
        checkOutput("stop_busy", int'(busy), 0);

        // UART abort in the middle of entry 1
        seq_start = 1;
        applyStimulus();
        seq_start = 0;
        tick = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus();
            if (cfg_strobe && seq_idx == 3'd1) found = 1;
        end
        checkOutput("reach_e1", int'(found), 1);
        tick = 0;
        applyStimulus();
        applyStimulus();
        uart_valid = 1; uart_wave = 3'd5; uart_freq = 6'd9; uart_noise = 1'b0;
        applyStimulus();
        uart_valid = 0;
        checkOutput("abort_wave", int'(wave_select), 5);
        checkOutput("abort_busy", int'(busy), 0);
        tick = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("abort_hold", int'(wave_select), 5);
            checkOutput("abort_nostrobe", int'(cfg_strobe), 0);
        end
        tick = 0;

        // seq_start and uart_valid together
        seq_start = 1; uart_valid = 1; uart_wave = 3'd6; uart_freq = 6'd40; uart_noise = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("both_wave", int'(wave_select), 6);
        checkOutput("both_busy", int'(busy), 0);
        applyStimulus();
        checkOutput("both_busy2", int'(busy), 0);

        // Reset during entry 2 clears the table
        seq_start = 1;
        tick = 1;
        applyStimulus();
        seq_start = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus();
            if (cfg_strobe && seq_idx == 3'd2) found = 1;
        end
        checkOutput("reach_e2", int'(found), 1);
        rst = 1; prog_we = 1; prog_addr = 3'd0; prog_wave = 3'd7; prog_dwell = 8'd9;
        uart_valid = 1; uart_wave = 3'd7;
        applyStimulus();
        clearInputs();
        checkOutput("mid_rst_wave", int'(wave_select), 0);
        checkOutput("mid_rst_freq", int'(freq_select), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_idx", int'(seq_idx), 0);
        seq_start = 1;
        applyStimulus();
        seq_start = 0;
        tick = 1;
        applyStimulus();
        checkOutput("zero_e0_strobe", int'(cfg_strobe), 1);
        checkOutput("zero_e0_wave", int'(wave_select), 0);
        applyStimulus();
        applyStimulus();
        checkOutput("zero_e1_strobe", int'(cfg_strobe), 1);
        checkOutput("zero_e1_idx", int'(seq_idx), 1);
        clearInputs();
        seq_stop = 1;
        applyStimulus();
        seq_stop = 0;

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            uart_valid = ($urandom_range(0, 39) == 0);
            uart_wave  = 3'($urandom_range(0, 7));
            uart_freq  = 6'($urandom_range(0, 63));
            uart_noise = 1'($urandom_range(0, 1));
            prog_we    = ($urandom_range(0, 4) == 0);
            prog_addr  = 3'($urandom_range(0, 7));
            prog_wave  = 3'($urandom_range(0, 7));
            prog_freq  = 6'($urandom_range(0, 63));
            prog_noise = 1'($urandom_range(0, 1));
            prog_dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) seq_last = 3'($urandom_range(0, 7));
            seq_start  = ($urandom_range(0, 7) == 0);
            seq_stop   = ($urandom_range(0, 59) == 0);
            tick       = ($urandom_range(0, 1) == 1);
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
